// File: rtl/alarm_clock_controller_pkg.sv
// Shared types for the alarm clock: FSM states, mode codes, BCD digit types.
// The 12 h display helper is only referenced when ALARM_CLOCK_TWELVE_HOUR_EN is defined.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } alarm_state_e;

  localparam logic [1:0] MODE_RUN       = 2'b00;
  localparam logic [1:0] MODE_SET_TIME  = 2'b01;
  localparam logic [1:0] MODE_SET_ALARM = 2'b10;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  // 24 h BCD hour -> 12 h BCD hour (00 -> 12, 13..23 -> 01..11)
  function automatic bcd2_t hour_to_12h(bcd2_t h);
    logic [4:0] b;
    bcd2_t      r;
    b = 5'({1'b0, h.tens} * 5'd10) + {1'b0, h.ones};
    if (b == 5'd0)       b = 5'd12;
    else if (b > 5'd12)  b = b - 5'd12;
    r.tens = (b >= 5'd10) ? 4'd1 : 4'd0;
    r.ones = (b >= 5'd10) ? 4'(b - 5'd10) : 4'(b);
    return r;
  endfunction

endpackage

// File: rtl/alarm_clock_controller_if.sv
// Control/display bundle between the alarm-clock top level and this controller.
interface alarm_clock_controller_if;
  import alarm_clock_pkg::*;

  logic [1:0] mode;
  logic       inc_hour;
  logic       inc_min;
  logic       alarm_enable;
  logic       snooze;
  logic       stop;
  bcd_t       bcd_digit0;
  bcd_t       bcd_digit1;
  bcd_t       bcd_digit2;
  bcd_t       bcd_digit3;
  bcd_t       bcd_digit4;
  bcd_t       bcd_digit5;
  logic       alarm_trigger;
  logic       sec_tick;

  modport master (
    output mode, inc_hour, inc_min, alarm_enable, snooze, stop,
    input  bcd_digit0, bcd_digit1, bcd_digit2, bcd_digit3, bcd_digit4, bcd_digit5,
    input  alarm_trigger, sec_tick
  );

  modport slave (
    input  mode, inc_hour, inc_min, alarm_enable, snooze, stop,
    output bcd_digit0, bcd_digit1, bcd_digit2, bcd_digit3, bcd_digit4, bcd_digit5,
    output alarm_trigger, sec_tick
  );

endinterface

// File: rtl/alarm_clock_controller_bcd2_counter.sv
// Two-digit BCD counter wrapping MAX -> 00, with sync clear and a carry on wrap.
// nxt_o exposes the next-state value so callers can compare against post-edge time.
module bcd2_counter
  import alarm_clock_pkg::*;
#(
  parameter int unsigned MAX     = 59,
  parameter bcd2_t       RST_VAL = '0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  inc_i,
  input  logic  clr_i,
  output bcd2_t q_o,
  output bcd2_t nxt_o,
  output logic  carry_o
);

  localparam bcd_t MAX_T = bcd_t'(MAX / 10);
  localparam bcd_t MAX_O = bcd_t'(MAX % 10);

  bcd2_t cnt_q, cnt_d;
  logic  at_max;

  assign at_max  = (cnt_q.tens == MAX_T) && (cnt_q.ones == MAX_O);
  assign carry_o = inc_i && !clr_i && at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (at_max) begin
        cnt_d = '0;
      end else if (cnt_q.ones == 4'd9) begin
        cnt_d.tens = cnt_q.tens + 4'd1;
        cnt_d.ones = 4'd0;
      end else begin
        cnt_d.ones = cnt_q.ones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RST_VAL;
    else        cnt_q <= cnt_d;
  end

  assign q_o   = cnt_q;
  assign nxt_o = cnt_d;

endmodule

// File: rtl/alarm_clock_controller.sv
// Alarm clock timekeeping, alarm set-point and ring/snooze sequencer with BCD display mux.
// Define ALARM_CLOCK_TWELVE_HOUR_EN for a 12 h hour display (state stays 24 h).
module alarm_clock_controller
  import alarm_clock_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 50_000_000,
  parameter int unsigned SNOOZE_SEC       = 300,
  parameter int unsigned RING_TIMEOUT_SEC = 60
) (
  input  logic                     clk,
  input  logic                     reset_n,
  alarm_clock_controller_if.slave  bus
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned SW = $clog2(SNOOZE_SEC + 1);
  localparam int unsigned RW = $clog2(RING_TIMEOUT_SEC + 1);
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);

  logic set_time, set_alarm, run;
  assign set_time  = (bus.mode == MODE_SET_TIME);
  assign set_alarm = (bus.mode == MODE_SET_ALARM);
  assign run       = !set_time && !set_alarm;

  // Prescaler keeps running in SET_ALARM so timekeeping continues there
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  assign tick  = !set_time && (pre_q == PRE_TC);
  assign pre_d = (set_time || tick) ? '0 : pre_q + PW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pre_q <= '0;
    else          pre_q <= pre_d;
  end

  bcd2_t sec_q, min_q, hour_q, min_nxt, hour_nxt, alm_min, alm_hour;
  bcd2_t sec_nxt_unused, alm_min_nxt_unused, alm_hour_nxt_unused;
  logic  sec_carry, min_carry, hour_carry_unused, alm_min_carry_unused, alm_hour_carry_unused;
  logic  min_inc, hour_inc;

  // In SET_TIME the buttons drive minutes/hours directly and carries are suppressed
  assign min_inc  = set_time ? bus.inc_min  : sec_carry;
  assign hour_inc = set_time ? bus.inc_hour : min_carry;

  bcd2_counter #(.MAX(59)) u_sec (
    .clk(clk), .rst_n(reset_n), .inc_i(tick), .clr_i(set_time),
    .q_o(sec_q), .nxt_o(sec_nxt_unused), .carry_o(sec_carry)
  );
  bcd2_counter #(.MAX(59)) u_min (
    .clk(clk), .rst_n(reset_n), .inc_i(min_inc), .clr_i(1'b0),
    .q_o(min_q), .nxt_o(min_nxt), .carry_o(min_carry)
  );
  bcd2_counter #(.MAX(23)) u_hour (
    .clk(clk), .rst_n(reset_n), .inc_i(hour_inc), .clr_i(1'b0),
    .q_o(hour_q), .nxt_o(hour_nxt), .carry_o(hour_carry_unused)
  );
  bcd2_counter #(.MAX(59)) u_alm_min (
    .clk(clk), .rst_n(reset_n), .inc_i(set_alarm && bus.inc_min), .clr_i(1'b0),
    .q_o(alm_min), .nxt_o(alm_min_nxt_unused), .carry_o(alm_min_carry_unused)
  );
  bcd2_counter #(.MAX(23), .RST_VAL(bcd2_t'{4'd0, 4'd6})) u_alm_hour (
    .clk(clk), .rst_n(reset_n), .inc_i(set_alarm && bus.inc_hour), .clr_i(1'b0),
    .q_o(alm_hour), .nxt_o(alm_hour_nxt_unused), .carry_o(alm_hour_carry_unused)
  );

  // Only a second tick rolling into HH:MM:00 can fire; manual edits never do
  logic alarm_hit;
  assign alarm_hit = tick && sec_carry && (min_nxt == alm_min) && (hour_nxt == alm_hour);

  alarm_state_e  st_q, st_d;
  logic [RW-1:0] ring_q, ring_d;
  logic [SW-1:0] snz_q, snz_d;

  always_comb begin
    st_d   = st_q;
    ring_d = ring_q;
    snz_d  = snz_q;
    if (!bus.alarm_enable || !run) begin
      st_d = ST_IDLE;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (alarm_hit) begin
            st_d   = ST_RINGING;
            ring_d = '0;
          end
        end
        ST_RINGING: begin
          if (bus.stop) begin
            st_d = ST_IDLE;
          end else if (bus.snooze) begin
            st_d  = ST_SNOOZED;
            snz_d = SW'(SNOOZE_SEC);
          end else if (tick) begin
            ring_d = ring_q + RW'(1);
            if (ring_d == RW'(RING_TIMEOUT_SEC)) st_d = ST_IDLE;
          end
        end
        ST_SNOOZED: begin
          if (bus.stop) begin
            st_d = ST_IDLE;
          end else if (tick) begin
            if (snz_q <= SW'(1)) begin
              st_d   = ST_RINGING;
              ring_d = '0;
              snz_d  = '0;
            end else begin
              snz_d = snz_q - SW'(1);
            end
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= ST_IDLE;
      ring_q <= '0;
      snz_q  <= '0;
    end else begin
      st_q   <= st_d;
      ring_q <= ring_d;
      snz_q  <= snz_d;
    end
  end

  bcd2_t hr_sel, hr_disp, min_disp, sec_disp;
  always_comb begin
    hr_sel   = set_alarm ? alm_hour : hour_q;
    min_disp = set_alarm ? alm_min  : min_q;
    sec_disp = set_alarm ? '0       : sec_q;
  end

`ifdef ALARM_CLOCK_TWELVE_HOUR_EN
  assign hr_disp = hour_to_12h(hr_sel);
`else
  assign hr_disp = hr_sel;
`endif

  assign bus.bcd_digit0    = sec_disp.ones;
  assign bus.bcd_digit1    = sec_disp.tens;
  assign bus.bcd_digit2    = min_disp.ones;
  assign bus.bcd_digit3    = min_disp.tens;
  assign bus.bcd_digit4    = hr_disp.ones;
  assign bus.bcd_digit5    = hr_disp.tens;
  assign bus.alarm_trigger = (st_q == ST_RINGING);
  assign bus.sec_tick      = tick && run;

endmodule
